// File: rtl/unidade_controle_pkg.sv
// State encoding shared by the control unit and anything that decodes db_estado.
package unidade_controle_pkg;

  localparam int ESTADO_W = 4;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL        = 4'b0000,
    PREPARACAO     = 4'b0001,
    ESPERA_JOGADA  = 4'b0010,
    REGISTRA       = 4'b0100,
    COMPARACAO     = 4'b0101,
    PROXIMA_JOGADA = 4'b0110,
    FIM_ACERTOU    = 4'b1010,
    FIM_ERROU      = 4'b1110,
    FIM_TIMEOUT    = 4'b1101
  } estado_t;

endpackage

// File: rtl/unidade_controle_contador_timeout.sv
// Modulo-TIMEOUT inactivity counter. fim flags the terminal count (TIMEOUT-1).
module contador_timeout #(
  parameter int TIMEOUT = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] TC = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Synchronous clear has priority over counting; wrap after terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (zera) begin
      cnt_d = '0;
    end else if (conta) begin
      if (cnt_q == TC) cnt_d = '0;
      else             cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, asynchronously cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign fim = (cnt_q == TC);

endmodule

// File: rtl/unidade_controle.sv
// Moore control unit for the memory-game datapath: one play per ROM address,
// with a per-play inactivity timeout.
//
// state          | meaning
// inicial        | idle, waiting for iniciar
// preparacao     | clear address counter and play register
// espera_jogada  | waiting for a play, timeout counter running
// registra       | load the play register
// comparacao     | compare play with memory word
// proxima_jogada | advance to next address
// fim_acertou    | all 16 plays matched
// fim_errou      | wrong play
// fim_timeout    | no play within TIMEOUT cycles
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registrarR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t state_q, state_d;
  logic    espera;
  logic    fim_tempo;

  assign espera = (state_q == ESPERA_JOGADA);

  // Counter restarts on every entry to espera_jogada because it is held clear elsewhere.
  contador_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (!espera),
    .conta (espera),
    .fim   (fim_tempo)
  );

  // State register; reset aborts any game immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= INICIAL;
    else        state_q <= state_d;
  end

  // Next-state logic; a play wins over a simultaneous timeout terminal count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:        if (iniciar) state_d = PREPARACAO;
      PREPARACAO:     state_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada_feita)   state_d = REGISTRA;
        else if (fim_tempo) state_d = FIM_TIMEOUT;
      end
      REGISTRA:       state_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)    state_d = FIM_ERROU;
        else if (fimC) state_d = FIM_ACERTOU;
        else           state_d = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: state_d = ESPERA_JOGADA;
      FIM_ACERTOU,
      FIM_ERROU,
      FIM_TIMEOUT:    if (iniciar) state_d = PREPARACAO;
      default:        state_d = INICIAL;
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    zeraC      = 1'b0;
    contaC     = 1'b0;
    zeraR      = 1'b0;
    registrarR = 1'b0;
    pronto     = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      PREPARACAO: begin
        zeraC = 1'b1;
        zeraR = 1'b1;
      end
      REGISTRA:       registrarR = 1'b1;
      PROXIMA_JOGADA: contaC     = 1'b1;
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = state_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with a short timeout.
module tb_unidade_controle;
  import unidade_controle_pkg::*;

  localparam int TIMEOUT = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       jogada_feita = 1'b0;
  logic       igual = 1'b0;
  logic       fimC = 1'b0;
  logic       zeraC, contaC, zeraR, registrarR;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;
  int conta_pulsos = 0;

  unidade_controle #(.TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .jogada_feita (jogada_feita),
    .igual        (igual),
    .fimC         (fimC),
    .zeraC        (zeraC),
    .contaC       (contaC),
    .zeraR        (zeraR),
    .registrarR   (registrarR),
    .pronto       (pronto),
    .acertou      (acertou),
    .errou        (errou),
    .timeout      (timeout),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (reset && contaC) conta_pulsos++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (db_estado !== 4'b0000) begin
      errors++; $display("FAIL reset_state: got %b want 0000", db_estado);
    end
    checks++;
    if ({zeraC, contaC, zeraR, registrarR, pronto, acertou, errou, timeout} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {zeraC, contaC, zeraR, registrarR, pronto, acertou, errou, timeout});
    end
    reset = 1'b1;
    tick();
    checks++;
    if (db_estado !== 4'b0000) begin
      errors++; $display("FAIL idle_no_start: got %b want 0000", db_estado);
    end
  endtask

  task automatic test_full_win();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    checks++;
    if (db_estado !== 4'b0001 || zeraC !== 1'b1 || zeraR !== 1'b1) begin
      errors++;
      $display("FAIL win_prep: got st=%b zeraC=%b zeraR=%b want 0001 1 1", db_estado, zeraC, zeraR);
    end
    tick();
    conta_pulsos = 0;
    checks++;
    if (db_estado !== 4'b0010) begin
      errors++; $display("FAIL win_espera: got %b want 0010", db_estado);
    end
    for (int p = 1; p <= 16; p++) begin
      jogada_feita = 1'b1;
      tick();
      jogada_feita = 1'b0;
      igual = 1'b1;
      fimC = (p == 16);
      if (db_estado !== 4'b0100 || registrarR !== 1'b1) begin
        checks++; errors++;
        $display("FAIL win_registra p=%0d: got st=%b regR=%b want 0100 1", p, db_estado, registrarR);
      end
      tick();
      tick();
      if (p < 16) begin
        if (db_estado !== 4'b0110 || contaC !== 1'b1) begin
          checks++; errors++;
          $display("FAIL win_proxima p=%0d: got st=%b contaC=%b want 0110 1", p, db_estado, contaC);
        end
        tick();
      end
    end
    fimC = 1'b0;
    checks++;
    if (db_estado !== 4'b1010) begin
      errors++; $display("FAIL win_state: got %b want 1010", db_estado);
    end
    checks++;
    if ({pronto, acertou, errou, timeout} !== 4'b1100) begin
      errors++; $display("FAIL win_flags: got %b want 1100", {pronto, acertou, errou, timeout});
    end
    checks++;
    if (conta_pulsos !== 15) begin
      errors++; $display("FAIL win_contaC_count: got %0d want 15", conta_pulsos);
    end
  endtask

  task automatic test_error_play3();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    conta_pulsos = 0;
    for (int p = 1; p <= 3; p++) begin
      jogada_feita = 1'b1;
      tick();
      jogada_feita = 1'b0;
      igual = (p != 3);
      fimC = 1'b0;
      tick();
      tick();
      if (p < 3) tick();
    end
    igual = 1'b0;
    checks++;
    if (db_estado !== 4'b1110) begin
      errors++; $display("FAIL err_state: got %b want 1110", db_estado);
    end
    checks++;
    if ({pronto, acertou, errou, timeout} !== 4'b1010) begin
      errors++; $display("FAIL err_flags: got %b want 1010", {pronto, acertou, errou, timeout});
    end
    checks++;
    if (conta_pulsos !== 2) begin
      errors++; $display("FAIL err_contaC_count: got %0d want 2", conta_pulsos);
    end
    tick();
    tick();
    tick();
    checks++;
    if (db_estado !== 4'b1110 || errou !== 1'b1) begin
      errors++; $display("FAIL err_hold: got st=%b errou=%b want 1110 1", db_estado, errou);
    end
  endtask

  task automatic test_restart();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    checks++;
    if (db_estado !== 4'b0001 || zeraC !== 1'b1 || zeraR !== 1'b1) begin
      errors++;
      $display("FAIL restart_prep: got st=%b zeraC=%b zeraR=%b want 0001 1 1", db_estado, zeraC, zeraR);
    end
    checks++;
    if ({pronto, acertou, errou, timeout} !== 4'b0000) begin
      errors++; $display("FAIL restart_flags: got %b want 0000", {pronto, acertou, errou, timeout});
    end
    tick();
    checks++;
    if (zeraC !== 1'b0 || zeraR !== 1'b0) begin
      errors++; $display("FAIL restart_one_cycle: got zeraC=%b zeraR=%b want 0 0", zeraC, zeraR);
    end
    iniciar = 1'b1;
    tick();
    tick();
    iniciar = 1'b0;
    checks++;
    if (db_estado !== 4'b0010) begin
      errors++; $display("FAIL iniciar_ignored: got %b want 0010", db_estado);
    end
  endtask

  // Enters espera_jogada afresh through a correct play, then lets it expire.
  task automatic test_timeout();
    jogada_feita = 1'b1;
    tick();
    jogada_feita = 1'b0;
    igual = 1'b1;
    fimC = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (db_estado !== 4'b0010) begin
      errors++; $display("FAIL to_reentry: got %b want 0010", db_estado);
    end
    for (int i = 1; i < TIMEOUT; i++) tick();
    checks++;
    if (db_estado !== 4'b0010) begin
      errors++; $display("FAIL to_early: got %b want 0010 after %0d cycles", db_estado, TIMEOUT - 1);
    end
    tick();
    checks++;
    if (db_estado !== 4'b1101) begin
      errors++; $display("FAIL to_state: got %b want 1101", db_estado);
    end
    checks++;
    if ({pronto, acertou, errou, timeout} !== 4'b1011) begin
      errors++; $display("FAIL to_flags: got %b want 1011", {pronto, acertou, errou, timeout});
    end
  endtask

  task automatic test_collision();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    for (int i = 1; i < TIMEOUT; i++) tick();
    jogada_feita = 1'b1;
    tick();
    jogada_feita = 1'b0;
    checks++;
    if (db_estado !== 4'b0100 || timeout !== 1'b0) begin
      errors++; $display("FAIL collision: got st=%b timeout=%b want 0100 0", db_estado, timeout);
    end
  endtask

  task automatic test_reset_mid();
    igual = 1'b1;
    fimC = 1'b0;
    tick();
    checks++;
    if (db_estado !== 4'b0101) begin
      errors++; $display("FAIL mid_comparacao: got %b want 0101", db_estado);
    end
    reset = 1'b0;
    #2;
    checks++;
    if (db_estado !== 4'b0000) begin
      errors++; $display("FAIL async_reset_state: got %b want 0000", db_estado);
    end
    checks++;
    if ({zeraC, contaC, zeraR, registrarR, pronto, acertou, errou, timeout} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b want 00000000",
               {zeraC, contaC, zeraR, registrarR, pronto, acertou, errou, timeout});
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (db_estado !== 4'b0000 || pronto !== 1'b0) begin
      errors++; $display("FAIL after_reset: got st=%b pronto=%b want 0000 0", db_estado, pronto);
    end
  endtask

  initial begin
    test_reset();
    test_full_win();
    test_error_play3();
    test_restart();
    test_timeout();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
